// File: rtl/registro_solicitudes_pkg.sv
// ascensor_pkg: shared definitions for the elevator request register and the
// dispatch state machine.
//   - bit indices of the request vector s
//   - field positions inside the car state word estado
//   - door FSM state type
//   - floor / serviced request masks
package ascensor_pkg;

    localparam int S_W = 10;

    // Request vector bit map
    localparam int S_P1_SUBIR = 0;
    localparam int S_P2_BAJAR = 1;
    localparam int S_P2_SUBIR = 2;
    localparam int S_P3_BAJAR = 3;
    localparam int S_P3_SUBIR = 4;
    localparam int S_P4_BAJAR = 5;
    localparam int S_CAB1     = 6;
    localparam int S_CAB2     = 7;
    localparam int S_CAB3     = 8;
    localparam int S_CAB4     = 9;

    // Car state word fields
    localparam int MOVING  = 3;
    localparam int DIR     = 2;
    localparam int FLOOR   = 0;
    localparam int FLOOR_W = 2;

    typedef enum logic {
        CERRADA = 1'b0,
        ABIERTA = 1'b1
    } puerta_t;

    // Every request that belongs to a floor: hall calls plus the cab button.
    function automatic logic [S_W-1:0] mascara_piso(input logic [FLOOR_W-1:0] piso);
        logic [S_W-1:0] m;
        m = '0;
        case (piso)
            2'd0: begin m[S_P1_SUBIR] = 1'b1; m[S_CAB1] = 1'b1; end
            2'd1: begin m[S_P2_BAJAR] = 1'b1; m[S_P2_SUBIR] = 1'b1; m[S_CAB2] = 1'b1; end
            2'd2: begin m[S_P3_BAJAR] = 1'b1; m[S_P3_SUBIR] = 1'b1; m[S_CAB3] = 1'b1; end
            2'd3: begin m[S_P4_BAJAR] = 1'b1; m[S_CAB4] = 1'b1; end
        endcase
        return m;
    endfunction

    // Requests a stop serves when the car arrives travelling in direction dir
    // (1 = up): the hall call for the opposite direction is left pending.
    function automatic logic [S_W-1:0] mascara_servida(input logic [FLOOR_W-1:0] piso,
                                                       input logic dir);
        logic [S_W-1:0] m;
        m = mascara_piso(piso);
        if (piso == 2'd1) begin
            if (dir) m[S_P2_BAJAR] = 1'b0;
            else     m[S_P2_SUBIR] = 1'b0;
        end else if (piso == 2'd2) begin
            if (dir) m[S_P3_BAJAR] = 1'b0;
            else     m[S_P3_SUBIR] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/registro_solicitudes_if.sv
// Bus between the dispatch machine (master) and the request register (slave).
//   botones : raw call button levels (bit map of s)
//   estado  : car state {moving, dir, floor[1:0]}
//   s       : latched requests
//   esperar : door open, dispatch holds while high
interface registro_solicitudes_if;
    import ascensor_pkg::*;

    logic [S_W-1:0] botones;
    logic [3:0]     estado;
    logic [S_W-1:0] s;
    logic           esperar;

    modport master (output botones, output estado, input s, input esperar);
    modport slave  (input botones, input estado, output s, output esperar);
endinterface

// File: rtl/registro_solicitudes_temporizador_puerta.sv
// temporizador_puerta: loadable down-counter timing the door opening.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load value (has priority over counting)
//   value      : reload value
//   done       : counter is at 1, i.e. last open cycle
// Counts down to 0 and holds there; never wraps.
module temporizador_puerta #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/registro_solicitudes.sv
// registro_solicitudes: latches call buttons into the request vector s,
// opens the door when the car rests at a floor and clears the requests that
// stop serves. esperar is high while the door is open.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of registro_solicitudes_if (botones, estado in;
//                s, esperar out)
//   DOOR_CYCLES: cycles the door stays open per opening (>= 1)
module registro_solicitudes
    import ascensor_pkg::*;
#(
    parameter int DOOR_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    registro_solicitudes_if.slave  bus
);

    localparam int CW = $clog2(DOOR_CYCLES + 1);

    logic               moving, dir;
    logic [FLOOR_W-1:0] piso;
    logic [S_W-1:0]     m_piso, m_servida;

    puerta_t        puerta_q, puerta_d;
    logic [S_W-1:0] s_q, s_d;
    logic [S_W-1:0] abierto_q, abierto_d;   // set cleared at the current opening
    logic           moving_q;
    logic           llegada, llamada, cargar, fin;

    assign moving    = bus.estado[MOVING];
    assign dir       = bus.estado[DIR];
    assign piso      = bus.estado[FLOOR +: FLOOR_W];
    assign m_piso    = mascara_piso(piso);
    assign m_servida = mascara_servida(piso, dir);

    // Stop = car was moving last cycle and is at rest now.
    assign llegada = moving_q & ~moving;
    // Idle at a floor with something pending for it, including the
    // opposite-direction hall call that dispatch ignores while idle.
    assign llamada = ~moving & ~llegada & (|(m_piso & (s_q | bus.botones)));

    always_comb begin
        puerta_d  = puerta_q;
        s_d       = s_q | bus.botones;
        abierto_d = abierto_q;
        cargar    = 1'b0;
        case (puerta_q)
            CERRADA: begin
                if (llegada) begin
                    puerta_d  = ABIERTA;
                    cargar    = 1'b1;
                    abierto_d = m_servida;
                    s_d       = (s_q | bus.botones) & ~m_servida;
                end else if (llamada) begin
                    puerta_d  = ABIERTA;
                    cargar    = 1'b1;
                    abierto_d = m_piso;
                    s_d       = (s_q | bus.botones) & ~m_piso;
                end
            end
            ABIERTA: begin
                // Presses of this opening's set hold the door instead of latching.
                // estado is not looked at here: a moving car with the door
                // open is ignored and the timer simply runs out.
                s_d = s_q | (bus.botones & ~abierto_q);
                if (|(bus.botones & abierto_q))
                    cargar = 1'b1;
                else if (fin)
                    puerta_d = CERRADA;
            end
            default: puerta_d = CERRADA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            puerta_q  <= CERRADA;
            s_q       <= '0;
            abierto_q <= '0;
            moving_q  <= 1'b0;
        end else begin
            puerta_q  <= puerta_d;
            s_q       <= s_d;
            abierto_q <= abierto_d;
            moving_q  <= moving;
        end
    end

    temporizador_puerta #(.W(CW)) u_temporizador (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cargar),
        .value (CW'(DOOR_CYCLES)),
        .done  (fin)
    );

    assign bus.s       = s_q;
    assign bus.esperar = (puerta_q == ABIERTA);

endmodule

// File: tb/tb_registro_solicitudes.sv
// Directed bench for registro_solicitudes (DOOR_CYCLES = 8). Each step drives
// inputs on the falling edge, queues the expected s/esperar, and compares
// them just after the following rising edge.
module tb_registro_solicitudes;

    typedef struct packed {
        logic [9:0] s;
        logic       e;
    } esp_t;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;
    esp_t cola[$];

    registro_solicitudes_if bus_if ();

    registro_solicitudes #(.DOOR_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic paso(input string tag, input logic r, input logic [9:0] bot,
                        input logic [3:0] est, input logic [9:0] es, input logic ee);
        esp_t x;
        @(negedge clk);
        rst_n          = r;
        bus_if.botones = bot;
        bus_if.estado  = est;
        cola.push_back('{s: es, e: ee});
        @(posedge clk);
        #1;
        x = cola.pop_front();
        nvec++;
        assert (bus_if.s === x.s) else begin
            nerr++;
            $error("FAIL %s s: got %h want %h", tag, bus_if.s, x.s);
        end
        assert (bus_if.esperar === x.e) else begin
            nerr++;
            $error("FAIL %s esperar: got %b want %b", tag, bus_if.esperar, x.e);
        end
    endtask

    task automatic abierta(input string tag, input int n, input logic [3:0] est,
                           input logic [9:0] es);
        for (int i = 0; i < n; i++) paso(tag, 1'b1, 10'h000, est, es, 1'b1);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        bus_if.botones = '0;
        bus_if.estado  = 4'b1000;

        // Reset with every button pressed
        paso("rst0", 1'b0, 10'h3FF, 4'b1000, 10'h000, 1'b0);
        paso("rst1", 1'b0, 10'h3FF, 4'b1000, 10'h000, 1'b0);
        paso("rel0", 1'b1, 10'h000, 4'b1000, 10'h000, 1'b0);
        paso("rel1", 1'b1, 10'h000, 4'b1000, 10'h000, 1'b0);

        // Latch cab 3, then stop at floor 3 going up
        paso("latch8", 1'b1, 10'h100, 4'b1101, 10'h100, 1'b0);
        paso("hold8",  1'b1, 10'h000, 4'b1101, 10'h100, 1'b0);
        paso("arr3",   1'b1, 10'h000, 4'b0110, 10'h000, 1'b1);
        abierta("open3", 7, 4'b0110, 10'h000);
        paso("close3", 1'b1, 10'h000, 4'b0110, 10'h000, 1'b0);
        paso("idle3",  1'b1, 10'h000, 4'b0110, 10'h000, 1'b0);

        // Direction filtering at floor 3, then idle reopen for the down call
        paso("lat34",  1'b1, 10'h018, 4'b1101, 10'h018, 1'b0);
        paso("hold34", 1'b1, 10'h000, 4'b1101, 10'h018, 1'b0);
        paso("arrup3", 1'b1, 10'h000, 4'b0110, 10'h008, 1'b1);
        abierta("openup3", 7, 4'b0110, 10'h008);
        paso("clsup3", 1'b1, 10'h000, 4'b0110, 10'h008, 1'b0);
        paso("reop3",  1'b1, 10'h000, 4'b0110, 10'h000, 1'b1);
        abierta("openid3", 7, 4'b0110, 10'h000);
        paso("clsid3", 1'b1, 10'h000, 4'b0110, 10'h000, 1'b0);

        // Reopen at floor 2 going up: press floor-2 up at open-cycle 5;
        // a floor-4 down press during the opening latches normally.
        paso("mov2",   1'b1, 10'h000, 4'b1001, 10'h000, 1'b0);
        paso("arr2",   1'b1, 10'h000, 4'b0101, 10'h000, 1'b1);
        paso("lat5",   1'b1, 10'h020, 4'b0101, 10'h020, 1'b1);
        abierta("open2a", 3, 4'b0101, 10'h020);
        paso("press2", 1'b1, 10'h004, 4'b0101, 10'h020, 1'b1);
        abierta("open2b", 7, 4'b0101, 10'h020);
        paso("close2", 1'b1, 10'h000, 4'b0101, 10'h020, 1'b0);

        // Arrival at floor 1 with cab 4 pressed on the same edge
        paso("pre1",   1'b1, 10'h041, 4'b1000, 10'h061, 1'b0);
        paso("arr1",   1'b1, 10'h200, 4'b0000, 10'h220, 1'b1);
        abierta("open1", 2, 4'b0000, 10'h220);

        // Reset in the middle of the opening
        paso("midrst", 1'b0, 10'h000, 4'b0000, 10'h000, 1'b0);
        paso("after",  1'b1, 10'h000, 4'b0000, 10'h000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
